// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the access-size encodings, the FSM state type, the number of byte lanes
// in a memory word, and a helper that returns the byte-lane mask of an access.
package lsu_pkg;

  // Access size encodings on the size input. 2'b11 is illegal.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte lanes in one 32-bit memory word.
  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRead  = 2'b01,
    StWrite = 2'b10,
    StDone  = 2'b11
  } lsu_state_e;

  // Byte lanes touched by an access of the given size at the given word offset.
  // Offsets are assumed already aligned for the size.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [1:0] offset);
    logic [NUM_LANES-1:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the load/store unit (little-endian).
// Ports:
//   rdata       - word read from memory
//   offset      - byte offset of the access within the word (addr[1:0])
//   size        - access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   is_unsigned - zero-extend loads when 1, sign-extend when 0
//   wdata       - right-justified store data
//   load_data   - extracted and extended load result
//   merged      - rdata with the store bytes replaced in their lanes
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]           byte_lane;
  logic [15:0]          half_lane;
  logic [31:0]          replicated;
  logic [NUM_LANES-1:0] mask;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = rdata[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: load_data = rdata;
    endcase
  end

  // Replicate store data across every lane it could land in, then pick per lane.
  always_comb begin
    case (size)
      SZ_BYTE: replicated = {4{wdata[7:0]}};
      SZ_HALF: replicated = {2{wdata[15:0]}};
      default: replicated = wdata;
    endcase
    mask   = lane_mask(size, offset);
    merged = rdata;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (mask[k]) begin
        merged[8*k +: 8] = replicated[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide, byte-addressed,
// little-endian data memory (combinational read, synchronous word write).
// Byte/half loads are extracted and extended; byte/half stores are done as
// read-modify-write. Misaligned accesses are aborted (CHECK_ALIGN=1) or have
// their low address bits forced aligned (CHECK_ALIGN=0).
// Ports:
//   i_LSU_clk, i_LSU_rst_n    - clock, async active-low reset
//   i_LSU_req/we/size/unsigned/addr/wData - request, sampled when IDLE or DONE
//   o_LSU_busy                - high in READ/WRITE
//   o_LSU_done                - one-cycle completion pulse
//   o_LSU_rData               - extended load result, held until next load
//   o_LSU_misalign            - valid with done; 1 = access aborted
//   o_LSU_memAddr/memWe/memWData, i_LSU_memRData - data memory interface
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic              i_LSU_clk,
  input  logic              i_LSU_rst_n,
  input  logic              i_LSU_req,
  input  logic              i_LSU_we,
  input  logic [1:0]        i_LSU_size,
  input  logic              i_LSU_unsigned,
  input  logic [ADDR_W-1:0] i_LSU_addr,
  input  logic [31:0]       i_LSU_wData,
  output logic              o_LSU_busy,
  output logic              o_LSU_done,
  output logic [31:0]       o_LSU_rData,
  output logic              o_LSU_misalign,
  output logic [ADDR_W-1:0] o_LSU_memAddr,
  output logic              o_LSU_memWe,
  output logic [31:0]       o_LSU_memWData,
  input  logic [31:0]       i_LSU_memRData
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              unsigned_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wbuf_q;
  logic [31:0]       rdata_q;
  logic              misalign_q;

  logic              accept;
  logic              req_misalign;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  // Request decode: misalignment check, or forced alignment when checking is off.
  always_comb begin
    req_size = i_LSU_size;
    req_addr = i_LSU_addr;
    case (i_LSU_size)
      SZ_BYTE: req_misalign = 1'b0;
      SZ_HALF: req_misalign = i_LSU_addr[0];
      SZ_WORD: req_misalign = |i_LSU_addr[1:0];
      default: req_misalign = 1'b1;
    endcase
    if (!CHECK_ALIGN) begin
      req_misalign = 1'b0;
      if (i_LSU_size == SZ_HALF) begin
        req_addr[0] = 1'b0;
      end else if (i_LSU_size != SZ_BYTE) begin
        // Illegal size is treated as a word access.
        req_addr[1:0] = 2'b00;
        req_size      = SZ_WORD;
      end
    end
  end

  assign accept = i_LSU_req & ((state_q == StIdle) | (state_q == StDone));

  lsu_lane_align u_lane_align (
    .rdata       (i_LSU_memRData),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged_word)
  );

  always_ff @(posedge i_LSU_clk or negedge i_LSU_rst_n) begin
    if (!i_LSU_rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      size_q     <= 2'b00;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      wbuf_q     <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            we_q       <= i_LSU_we;
            unsigned_q <= i_LSU_unsigned;
            wdata_q    <= i_LSU_wData;
            misalign_q <= req_misalign;
            if (req_misalign) begin
              state_q <= StDone;
            end else if (i_LSU_we && (req_size == SZ_WORD)) begin
              // Full-word store needs no read; buffer the data directly.
              wbuf_q  <= i_LSU_wData;
              state_q <= StWrite;
            end else begin
              state_q <= StRead;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRead: begin
          if (we_q) begin
            wbuf_q  <= merged_word;
            state_q <= StWrite;
          end else begin
            rdata_q <= load_data;
            state_q <= StDone;
          end
        end
        StWrite: state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode straight from registers; memWe has no path from the request.
  assign o_LSU_busy     = (state_q == StRead) | (state_q == StWrite);
  assign o_LSU_done     = (state_q == StDone);
  assign o_LSU_memWe    = (state_q == StWrite);
  assign o_LSU_misalign = misalign_q;
  assign o_LSU_rData    = rdata_q;
  assign o_LSU_memAddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_LSU_memWData = wbuf_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected completions
// and memory writes; a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, misalign, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          cyc;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  done_exp_t dq[$];
  wr_exp_t   wq[$];

  load_store_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .i_LSU_clk      (clk),
    .i_LSU_rst_n    (rst_n),
    .i_LSU_req      (req),
    .i_LSU_we       (we),
    .i_LSU_size     (size),
    .i_LSU_unsigned (uns),
    .i_LSU_addr     (addr),
    .i_LSU_wData    (wdata),
    .o_LSU_busy     (busy),
    .o_LSU_done     (done),
    .o_LSU_rData    (rdata),
    .o_LSU_misalign (misalign),
    .o_LSU_memAddr  (mem_addr),
    .o_LSU_memWe    (mem_we),
    .o_LSU_memWData (mem_wdata),
    .i_LSU_memRData (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[7:2]];

  // Memory model: initial contents plus synchronous word write, one process.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;  // 0x10
    mem[8] = 32'h01020304;  // 0x20
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every done pulse and every write cycle against the queues.
  always @(negedge clk) begin
    if (done) begin
      if (dq.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        done_exp_t e;
        e = dq.pop_front();
        chk("rdata", rdata, e.rd);
        chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
        chk("done_cycle", cyc, e.cyc);
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) begin
        fail_now("unexpected_mem_we");
      end else begin
        wr_exp_t w;
        w = wq.pop_front();
        chk("mem_addr", mem_addr, w.addr);
        chk("mem_wdata", mem_wdata, w.data);
        chk("busy_in_write", {31'b0, busy}, 32'd1);
      end
    end
  end

  // Caller is positioned at a negedge. Drives one request through its accept
  // edge and pushes the expected completion (lat = done cycle after accept).
  task automatic start(input logic s_we, input logic [1:0] s_size, input logic s_uns,
                       input logic [31:0] s_addr, input logic [31:0] s_wd,
                       input logic [31:0] exp_rd, input logic exp_mis, input int lat,
                       input logic exp_wr, input logic [31:0] exp_waddr,
                       input logic [31:0] exp_wdata, input logic push);
    done_exp_t e;
    wr_exp_t   w;
    req   = 1'b1;
    we    = s_we;
    size  = s_size;
    uns   = s_uns;
    addr  = s_addr;
    wdata = s_wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    if (push) begin
      e.rd  = exp_rd;
      e.mis = exp_mis;
      e.cyc = cyc + lat - 1;
      dq.push_back(e);
      if (exp_wr) begin
        w.addr = exp_waddr;
        w.data = exp_wdata;
        wq.push_back(w);
      end
    end
  endtask

  // Returns at the negedge where done is seen; bounded.
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) fail_now("done_timeout");
  endtask

  task automatic op(input logic s_we, input logic [1:0] s_size, input logic s_uns,
                    input logic [31:0] s_addr, input logic [31:0] s_wd,
                    input logic [31:0] exp_rd, input logic exp_mis, input int lat,
                    input logic exp_wr, input logic [31:0] exp_wdata);
    @(negedge clk);
    start(s_we, s_size, s_uns, s_addr, s_wd, exp_rd, exp_mis, lat, exp_wr,
          {s_addr[31:2], 2'b00}, exp_wdata, 1'b1);
    wait_done();
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word load and extensions.
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 1'b0, 32'h0);
    op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1'b0, 32'h0);
    op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 1'b0, 32'h0);
    op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 1'b0, 32'h0);
    op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 2, 1'b0, 32'h0);

    // Byte store (read-modify-write), then readback.
    op(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677, 32'h0000AABB, 1'b0, 3, 1'b1, 32'h889977BB);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h889977BB, 1'b0, 2, 1'b0, 32'h0);

    // Misaligned half store, word load and illegal size: aborted, rData held.
    op(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 32'h889977BB, 1'b1, 1, 1'b0, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h889977BB, 1'b1, 1, 1'b0, 32'h0);
    op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h889977BB, 1'b1, 1, 1'b0, 32'h0);
    chk("mem_after_misalign", mem[4], 32'h889977BB);

    // Upper half store merge, then readback (misalign cleared on accept).
    op(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CAFE, 32'h889977BB, 1'b0, 3, 1'b1, 32'hCAFE77BB);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFE77BB, 1'b0, 2, 1'b0, 32'h0);

    // Request pulse during READ is ignored (a store would show as a write).
    @(negedge clk);
    start(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFE77BB, 1'b0, 2, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'h55555555;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    wait_done();

    // New load accepted in the DONE cycle.
    start(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h000000BB, 1'b0, 2, 1'b0, 32'h0, 32'h0, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("mem_0x30_untouched", mem[12], 32'h0);

    // Reset in the middle of a word store.
    @(negedge clk);
    start(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    chk("we_before_reset", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("we_async_drop", {31'b0, mem_we}, 32'd0);
    chk("rst2_busy", {31'b0, busy}, 32'd0);
    chk("rst2_rdata", rdata, 32'h0);
    chk("rst2_mem_addr", mem_addr, 32'h0);
    chk("rst2_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("mem_0x20_unchanged", mem[8], 32'h01020304);
    rst_n = 1'b1;
    op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h01020304, 1'b0, 2, 1'b0, 32'h0);
    op(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h01020304, 1'b0, 2, 1'b1, 32'hDEADBEEF);
    op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    chk("pending_done", dq.size(), 32'd0);
    chk("pending_writes", wq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
